on_inverse: RTL and testbench



---
 rtl/on_inverse_pkg.sv | 17 +
 rtl/on_inverse_if.sv | 29 ++
 rtl/on_eval.sv | 22 ++
 rtl/on_inverse.sv | 105 ++++++++++
 tb/tb_on_inverse.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/on_inverse_pkg.sv
// Shared types and constants for the on_inverse pre-image search.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package on_inverse_pkg;

    localparam int VEC_W = 4;
    localparam int CNT_W = 5;

    localparam logic [VEC_W-1:0] LAST_VEC = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/on_inverse_if.sv
// Control handshake plus match stream between a controller and on_inverse.
// Latency: n/a (wiring only).
// Backpressure: match_ready from the master stalls the match stream.
interface on_inverse_if;
    import on_inverse_pkg::*;

    logic             start;
    logic             F1_req;
    logic             F2_req;
    logic             busy;
    logic             match_valid;
    logic [VEC_W-1:0] match_vec;
    logic             match_ready;
    logic             done;
    logic [CNT_W-1:0] match_count;

    // Controller / consumer side.
    modport master (
        output start, F1_req, F2_req, match_ready,
        input  busy, match_valid, match_vec, done, match_count
    );

    // Search engine side.
    modport slave (
        input  start, F1_req, F2_req, match_ready,
        output busy, match_valid, match_vec, done, match_count
    );

endinterface

// File: rtl/on_eval.sv
// Forward 4-in/2-out logic function: {A,B,C,D} -> {F1,F2}.
// Latency: purely combinational.
// Backpressure: none.
module on_eval
    import on_inverse_pkg::*;
(
    input  logic [VEC_W-1:0] i_vec,
    output logic             o_f1,
    output logic             o_f2
);

    logic w_a, w_b, w_c, w_d;
    logic w_t1, w_t2;

    assign {w_a, w_b, w_c, w_d} = i_vec;

    assign w_t2 = ~w_a & w_b;
    assign w_t1 = ~w_b & w_c;
    assign o_f2 = w_t2 | w_d;
    assign o_f1 = w_t1 | w_a | (w_t2 ^ w_d);

endmodule

// File: rtl/on_inverse.sv
// Enumerates all 16 input vectors and streams those whose forward result matches the target.
// Latency: 18 cycles from accepted start to busy low with match_ready high; +1 per stalled cycle.
// Backpressure: a hit with match_ready low holds candidate, match_valid and match_vec stable.
module on_inverse
    import on_inverse_pkg::*;
#(
    parameter int MAX_MATCHES = 16   // legal range 1..16
) (
    input  logic         clk,
    input  logic         rst,
    on_inverse_if.slave  bus
);

    state_t           r_state;
    logic [VEC_W-1:0] r_cand;
    logic             r_f1_tgt;
    logic             r_f2_tgt;
    logic [CNT_W-1:0] r_count;
    logic             r_busy;
    logic             r_done;

    logic w_f1;
    logic w_f2;
    logic w_scan;
    logic w_hit;
    logic w_valid;
    logic w_hshk;
    logic w_adv;
    logic w_last;
    logic w_cap;

    on_eval u_eval (
        .i_vec (r_cand),
        .o_f1  (w_f1),
        .o_f2  (w_f2)
    );

    // Everything below is decoded from registers only, so start/F*_req never
    // reach the stream outputs combinationally.
    assign w_scan  = (r_state == SCAN);
    assign w_hit   = (w_f1 == r_f1_tgt) && (w_f2 == r_f2_tgt);
    assign w_valid = w_scan && w_hit;
    assign w_hshk  = w_valid && bus.match_ready;
    assign w_adv   = !w_hit || bus.match_ready;
    assign w_last  = (r_cand == LAST_VEC);
    // The handshake that takes the count to MAX_MATCHES ends the search.
    assign w_cap   = (r_count == CNT_W'(MAX_MATCHES - 1));

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.match_valid = w_valid;
    assign bus.match_vec   = w_scan ? r_cand : '0;
    assign bus.match_count = r_count;

    // Search FSM: latch targets on start, walk candidates with stall on unaccepted hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_f1_tgt <= 1'b0;
            r_f2_tgt <= 1'b0;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_f1_tgt <= bus.F1_req;
                        r_f2_tgt <= bus.F2_req;
                        r_cand   <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_hshk) begin
                        r_count <= r_count + CNT_W'(1);
                    end
                    if (w_adv) begin
                        // No wrap: the last candidate is tested explicitly.
                        if (w_last || (w_hshk && w_cap)) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_cand <= r_cand + VEC_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_on_inverse.sv
// Self-checking bench for on_inverse: directed latency/boundary cases plus random searches.
// Latency: n/a.
// Backpressure: match_ready driven directly and at random.
module tb_on_inverse;
    import on_inverse_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    on_inverse_if bus  ();
    on_inverse_if bus2 ();

    on_inverse #(.MAX_MATCHES(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    on_inverse #(.MAX_MATCHES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic [3:0] ref_vec;
    logic       ref_f1;
    logic       ref_f2;

    on_eval u_ref (
        .i_vec (ref_vec),
        .o_f1  (ref_f1),
        .o_f2  (ref_f2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Pre-image sets as bit masks, indexed by {F1,F2}.
    logic [15:0] pre [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic samp(input bit sel, output logic o_busy, output logic o_valid,
                        output logic o_done, output logic [3:0] o_vec, output logic [4:0] o_cnt);
        if (sel) begin
            o_busy = bus2.busy; o_valid = bus2.match_valid; o_done = bus2.done;
            o_vec  = bus2.match_vec; o_cnt = bus2.match_count;
        end else begin
            o_busy = bus.busy; o_valid = bus.match_valid; o_done = bus.done;
            o_vec  = bus.match_vec; o_cnt = bus.match_count;
        end
    endtask

    task automatic drv_start(input bit sel, input logic s, input logic f1, input logic f2);
        if (sel) begin
            bus2.start = s; bus2.F1_req = f1; bus2.F2_req = f2;
        end else begin
            bus.start = s; bus.F1_req = f1; bus.F2_req = f2;
        end
    endtask

    task automatic check_idle(input bit sel, input string tag);
        logic b, v, d;
        logic [3:0] vec;
        logic [4:0] cnt;
        samp(sel, b, v, d, vec, cnt);
        check({tag, "_busy"},  32'(b),   32'd0);
        check({tag, "_valid"}, 32'(v),   32'd0);
        check({tag, "_vec"},   32'(vec), 32'd0);
        check({tag, "_done"},  32'(d),   32'd0);
        check({tag, "_count"}, 32'(cnt), 32'd0);
    endtask

    // One search: model walks candidates 0..15, stalling on hits without ready.
    task automatic run_search(input bit sel, input logic f1, input logic f2, input int maxm,
                              input bit rnd, input int stall_vec, input int stall_len,
                              input int start2_cyc, input int rst_cyc, input bit sdone,
                              input bit no_wait, input int exp_done, input int exp_cnt);
        logic [15:0] mask;
        int   k, cand_m, acc, stalls;
        bit   fin, hit;
        logic rd;
        logic b, v, d;
        logic [3:0] vec;
        logic [4:0] cnt;

        mask = pre[{f1, f2}];
        if (!no_wait) @(negedge clk);
        drv_start(sel, 1'b1, f1, f2);
        @(posedge clk);
        #1;
        // Scramble targets after acceptance: they must already be latched.
        drv_start(sel, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        cand_m = 0; acc = 0; stalls = 0; fin = 1'b0; k = 1;
        while (!fin && k < 80) begin
            rd = rnd ? 1'($urandom_range(0, 2) != 0) : 1'b1;
            if (cand_m == stall_vec && stalls < stall_len) rd = 1'b0;
            bus.match_ready  = rd;
            bus2.match_ready = rd;
            if (k == start2_cyc) drv_start(sel, 1'b1, 1'b0, 1'b0);
            if (k == rst_cyc) rst = 1'b1;

            @(negedge clk);
            samp(sel, b, v, d, vec, cnt);
            hit = mask[cand_m];
            check("scan_busy",  32'(b),   32'd1);
            check("scan_done",  32'(d),   32'd0);
            check("scan_valid", 32'(v),   32'(hit));
            check("scan_vec",   32'(vec), 32'(cand_m));

            if (k == rst_cyc) begin
                @(posedge clk);
                #1;
                rst = 1'b0;
                drv_start(sel, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                check_idle(sel, "abort");
                return;
            end

            if (hit && rd) begin
                acc++;
                if (acc == maxm || cand_m == 15) fin = 1'b1;
                else cand_m++;
            end else if (hit) begin
                stalls++;
            end else begin
                if (cand_m == 15) fin = 1'b1;
                else cand_m++;
            end

            @(posedge clk);
            #1;
            if (k == start2_cyc) drv_start(sel, 1'b0, 1'b0, 1'b0);
            k++;
        end
        check("search_finished", 32'(fin), 32'd1);

        // k is now the DONE cycle.
        if (sdone) drv_start(sel, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        samp(sel, b, v, d, vec, cnt);
        check("done_pulse", 32'(d),   32'd1);
        check("done_busy",  32'(b),   32'd1);
        check("done_valid", 32'(v),   32'd0);
        check("done_vec",   32'(vec), 32'd0);
        check("done_count", 32'(cnt), 32'(acc));
        if (exp_done >= 0) check("done_cycle", 32'(k),   32'(exp_done));
        if (exp_cnt >= 0)  check("match_count", 32'(cnt), 32'(exp_cnt));

        @(posedge clk);
        #1;
        drv_start(sel, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        samp(sel, b, v, d, vec, cnt);
        check("idle_busy",  32'(b),   32'd0);
        check("idle_done",  32'(d),   32'd0);
        check("idle_count", 32'(cnt), 32'(acc));
    endtask

    initial begin
        pre[0] = 16'h0001;   // {0}
        pre[1] = 16'h00A0;   // {5,7}
        pre[2] = 16'h5504;   // {2,8,10,12,14}
        pre[3] = 16'hAA5A;   // {1,3,4,6,9,11,13,15}

        rst = 1'b1;
        bus.start  = 1'b0; bus.F1_req  = 1'b0; bus.F2_req  = 1'b0; bus.match_ready  = 1'b0;
        bus2.start = 1'b0; bus2.F1_req = 1'b0; bus2.F2_req = 1'b0; bus2.match_ready = 1'b0;
        ref_vec = '0;

        // Forward function against the reference pre-image table.
        for (int i = 0; i < 16; i++) begin
            ref_vec = 4'(i);
            #1;
            check("eval_f1f2", 32'({ref_f1, ref_f2}),
                  32'(pre[3][i] ? 2'd3 : pre[2][i] ? 2'd2 : pre[1][i] ? 2'd1 : 2'd0));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(1'b0, "reset");
        check_idle(1'b1, "reset2");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle(1'b0, "post_reset");

        //          sel f1    f2    max rnd stv stl st2 rst sdn nw  done cnt
        run_search(1'b0, 1'b0, 1'b0, 16, 1'b0, -1, 0, -1, -1, 1'b0, 1'b0, 17, 1);
        run_search(1'b0, 1'b1, 1'b0, 16, 1'b0, -1, 0, -1, -1, 1'b0, 1'b1, 17, 5);
        run_search(1'b0, 1'b1, 1'b1, 16, 1'b0,  4, 3, -1, -1, 1'b0, 1'b0, 20, 8);
        run_search(1'b1, 1'b1, 1'b1,  2, 1'b0, -1, 0, -1, -1, 1'b0, 1'b0,  5, 2);
        run_search(1'b0, 1'b0, 1'b1, 16, 1'b0, -1, 0,  4, -1, 1'b0, 1'b0, 17, 2);
        run_search(1'b0, 1'b1, 1'b1, 16, 1'b0, -1, 0, -1,  6, 1'b0, 1'b0, -1, -1);
        run_search(1'b0, 1'b1, 1'b0, 16, 1'b0, -1, 0, -1, -1, 1'b1, 1'b0, 17, 5);
        run_search(1'b0, 1'b0, 1'b0, 16, 1'b0, -1, 0, -1, -1, 1'b0, 1'b1, 17, 1);

        for (int i = 0; i < 24; i++) begin
            bit s;
            s = 1'($urandom_range(0, 1));
            run_search(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s ? 2 : 16,
                       1'b1, -1, 0, -1, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
